// File: rtl/if_fetch_queue.sv
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Fetch-side tag FIFO plus compacting instruction queue feeding ID.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_queue #(
   parameter int FETCH_W   = 2,
   parameter int ISSUE_W   = 2,
   parameter int DEPTH     = 8,
   parameter int MAX_OUTST = 4,
   parameter int EXC_W     = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     req_fire_i,
   input  logic                     req_excep_i,
   input  logic [31:0]              req_pc_i,
   input  logic [FETCH_W-1:0]       req_mask_i,
   input  logic [EXC_W-1:0]         req_exc_type_i,
   output logic                     can_req_o,
   input  logic                     data_ok_i,
   input  logic [32*FETCH_W-1:0]    rdata_i,
   input  logic                     id_allowin_i,
   output logic [ISSUE_W-1:0]       out_valid_o,
   output logic [32*ISSUE_W-1:0]    out_inst_o,
   output logic [32*ISSUE_W-1:0]    out_pc_o,
   output logic [ISSUE_W-1:0]       out_excep_en_o,
   output logic [EXC_W*ISSUE_W-1:0] out_exc_type_o
);

   localparam int c_PW  = $clog2(DEPTH);
   localparam int c_QCW = $clog2(DEPTH + 1);
   localparam int c_TPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int c_OW  = $clog2(MAX_OUTST + 1);
   localparam int c_FCW = $clog2(FETCH_W + 1);
   localparam int c_ICW = $clog2(ISSUE_W + 1);

   // Tag FIFO storage
   logic [31:0]         r_tag_pc   [MAX_OUTST];
   logic [FETCH_W-1:0]  r_tag_mask [MAX_OUTST];
   logic                r_tag_exc  [MAX_OUTST];
   logic [EXC_W-1:0]    r_tag_type [MAX_OUTST];
   logic [c_TPW-1:0]    r_tag_wptr;
   logic [c_TPW-1:0]    r_tag_rptr;
   logic [c_OW-1:0]     r_tag_count;

   // Instruction queue storage
   logic [31:0]         r_q_inst [DEPTH];
   logic [31:0]         r_q_pc   [DEPTH];
   logic                r_q_exc  [DEPTH];
   logic [EXC_W-1:0]    r_q_type [DEPTH];
   logic [c_PW-1:0]     r_q_wptr;
   logic [c_PW-1:0]     r_q_rptr;
   logic [c_QCW-1:0]    r_q_count;

   logic [c_OW-1:0]     r_mem_outst;
   logic [c_OW-1:0]     r_discard;

   logic                w_head_valid;
   logic                w_head_exc;
   logic [31:0]         w_head_pc;
   logic [FETCH_W-1:0]  w_head_mask;
   logic [EXC_W-1:0]    w_head_type;
   logic                w_mem_retire;
   logic                w_exc_retire;
   logic                w_tag_push;
   logic                w_tag_pop;
   logic                w_drop;
   logic [c_FCW-1:0]    w_mask_cnt;
   logic [c_FCW-1:0]    w_push_cnt;
   logic [c_ICW-1:0]    w_pop_cnt;
   logic [ISSUE_W-1:0]  w_slot_valid;
   logic [ISSUE_W-1:0]  w_slot_exc;
   logic                w_seen_exc;
   logic [c_TPW-1:0]    w_tag_wptr_nxt;
   logic [c_TPW-1:0]    w_tag_rptr_nxt;

   assign w_head_valid = (r_tag_count != '0);
   assign w_head_exc   = r_tag_exc[r_tag_rptr];
   assign w_head_pc    = r_tag_pc[r_tag_rptr];
   assign w_head_mask  = r_tag_mask[r_tag_rptr];
   assign w_head_type  = r_tag_type[r_tag_rptr];

   // New-path tags wait until every cancelled return has drained
   assign w_mem_retire = !flush_i && w_head_valid && !w_head_exc && data_ok_i
                         && (r_discard == '0);
   assign w_exc_retire = !flush_i && w_head_valid && w_head_exc
                         && (r_discard == '0) && (32'(r_q_count) < 32'(DEPTH));
   assign w_tag_pop    = w_mem_retire || w_exc_retire;
   assign w_tag_push   = req_fire_i && !flush_i;
   assign w_drop       = !flush_i && data_ok_i && (r_discard != '0);

   assign w_tag_wptr_nxt = (r_tag_wptr == c_TPW'(MAX_OUTST - 1)) ? '0 : r_tag_wptr + c_TPW'(1);
   assign w_tag_rptr_nxt = (r_tag_rptr == c_TPW'(MAX_OUTST - 1)) ? '0 : r_tag_rptr + c_TPW'(1);

   always_comb begin
      w_mask_cnt = '0;
      for (int k = 0; k < FETCH_W; k++) begin
         w_mask_cnt = w_mask_cnt + c_FCW'(w_head_mask[k]);
      end
   end

   assign w_push_cnt = w_mem_retire ? w_mask_cnt :
                       w_exc_retire ? c_FCW'(1) : '0;

   // Reservation assumes every queued tag may still deliver a full packet
   assign can_req_o = (r_tag_count < c_OW'(MAX_OUTST))
                      && ((32'(r_mem_outst) + 32'(r_discard)) < 32'(MAX_OUTST))
                      && ((32'(r_q_count) + 32'(FETCH_W) * (32'(r_tag_count) + 32'd1))
                          <= 32'(DEPTH));

   always_comb begin
      w_seen_exc = 1'b0;
      w_pop_cnt  = '0;
      for (int j = 0; j < ISSUE_W; j++) begin
         w_slot_valid[j] = (32'(r_q_count) > 32'(j)) && !w_seen_exc;
         w_seen_exc      = w_seen_exc | w_slot_exc[j];
         if (w_slot_valid[j] && id_allowin_i) begin
            w_pop_cnt = w_pop_cnt + c_ICW'(1);
         end
      end
   end

   for (genvar j = 0; j < ISSUE_W; j++) begin : g_slot
      logic [c_PW-1:0] w_idx;
      assign w_idx         = r_q_rptr + c_PW'(j);
      assign w_slot_exc[j] = r_q_exc[w_idx];
      assign out_valid_o[j]                 = w_slot_valid[j];
      assign out_inst_o[32*j +: 32]         = w_slot_valid[j] ? r_q_inst[w_idx] : '0;
      assign out_pc_o[32*j +: 32]           = w_slot_valid[j] ? r_q_pc[w_idx]   : '0;
      assign out_excep_en_o[j]              = w_slot_valid[j] && r_q_exc[w_idx];
      assign out_exc_type_o[EXC_W*j +: EXC_W] = w_slot_valid[j] ? r_q_type[w_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_wptr  <= '0;
         r_tag_rptr  <= '0;
         r_tag_count <= '0;
         r_q_wptr    <= '0;
         r_q_rptr    <= '0;
         r_q_count   <= '0;
         r_mem_outst <= '0;
         r_discard   <= '0;
      end else if (flush_i) begin
         r_tag_wptr  <= '0;
         r_tag_rptr  <= '0;
         r_tag_count <= '0;
         r_q_wptr    <= '0;
         r_q_rptr    <= '0;
         r_q_count   <= '0;
         r_mem_outst <= '0;
         // Everything still owed by memory, including this cycle's fire, is dropped later
         r_discard   <= c_OW'(32'(r_discard) + 32'(r_mem_outst)
                              + 32'(req_fire_i && !req_excep_i) - 32'(data_ok_i));
      end else begin
         if (w_tag_push) r_tag_wptr <= w_tag_wptr_nxt;
         if (w_tag_pop)  r_tag_rptr <= w_tag_rptr_nxt;
         r_tag_count <= r_tag_count + c_OW'(w_tag_push) - c_OW'(w_tag_pop);
         r_mem_outst <= r_mem_outst + c_OW'(w_tag_push && !req_excep_i) - c_OW'(w_mem_retire);
         if (w_drop) r_discard <= r_discard - c_OW'(1);
         r_q_wptr  <= r_q_wptr + c_PW'(w_push_cnt);
         r_q_rptr  <= r_q_rptr + c_PW'(w_pop_cnt);
         r_q_count <= r_q_count + c_QCW'(w_push_cnt) - c_QCW'(w_pop_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (w_tag_push) begin
         r_tag_pc[r_tag_wptr]   <= req_pc_i;
         r_tag_mask[r_tag_wptr] <= req_mask_i;
         r_tag_exc[r_tag_wptr]  <= req_excep_i;
         r_tag_type[r_tag_wptr] <= req_exc_type_i;
      end
      // Mask is contiguous from bit 0, so slot k lands at wptr+k
      for (int k = 0; k < FETCH_W; k++) begin
         if (w_mem_retire && w_head_mask[k]) begin
            r_q_inst[r_q_wptr + c_PW'(k)] <= rdata_i[32*k +: 32];
            r_q_pc[r_q_wptr + c_PW'(k)]   <= w_head_pc + 32'(4 * k);
            r_q_exc[r_q_wptr + c_PW'(k)]  <= 1'b0;
            r_q_type[r_q_wptr + c_PW'(k)] <= '0;
         end
      end
      if (w_exc_retire) begin
         r_q_inst[r_q_wptr] <= '0;
         r_q_pc[r_q_wptr]   <= w_head_pc;
         r_q_exc[r_q_wptr]  <= 1'b1;
         r_q_type[r_q_wptr] <= w_head_type;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Directed self-checking bench for if_fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        req_fire_i;
   logic        req_excep_i;
   logic [31:0] req_pc_i;
   logic [1:0]  req_mask_i;
   logic [19:0] req_exc_type_i;
   logic        can_req_o;
   logic        data_ok_i;
   logic [63:0] rdata_i;
   logic        id_allowin_i;
   logic [1:0]  out_valid_o;
   logic [63:0] out_inst_o;
   logic [63:0] out_pc_o;
   logic [1:0]  out_excep_en_o;
   logic [39:0] out_exc_type_o;

   int checks   = 0;
   int failures = 0;

   if_fetch_queue #(
      .FETCH_W(2), .ISSUE_W(2), .DEPTH(8), .MAX_OUTST(4), .EXC_W(20)
   ) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .req_fire_i(req_fire_i), .req_excep_i(req_excep_i), .req_pc_i(req_pc_i),
      .req_mask_i(req_mask_i), .req_exc_type_i(req_exc_type_i), .can_req_o(can_req_o),
      .data_ok_i(data_ok_i), .rdata_i(rdata_i), .id_allowin_i(id_allowin_i),
      .out_valid_o(out_valid_o), .out_inst_o(out_inst_o), .out_pc_o(out_pc_o),
      .out_excep_en_o(out_excep_en_o), .out_exc_type_o(out_exc_type_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic fire(input logic [31:0] pc, input logic [1:0] mask,
                       input logic excep, input logic [19:0] typ);
      req_fire_i = 1'b1; req_pc_i = pc; req_mask_i = mask;
      req_excep_i = excep; req_exc_type_i = typ;
   endtask

   task automatic unfire();
      req_fire_i = 1'b0; req_excep_i = 1'b0; req_pc_i = '0;
      req_mask_i = '0; req_exc_type_i = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush_i = 1'b0; data_ok_i = 1'b0; rdata_i = '0; id_allowin_i = 1'b0;
      unfire();
      cyc(); cyc();
      rst = 1'b0;
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", out_valid_o); end
      checks++; if (out_inst_o !== 64'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", out_inst_o); end
      checks++; if (out_pc_o !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc_o); end
      checks++; if (can_req_o !== 1'b1) begin failures++; $display("FAIL reset_can_req got=%b exp=1", can_req_o); end
   endtask

   task automatic test_basic();
      fire(32'h1c000000, 2'b11, 1'b0, '0);
      cyc();
      unfire(); data_ok_i = 1'b1; rdata_i = {32'h2, 32'h1}; id_allowin_i = 1'b1;
      cyc();
      data_ok_i = 1'b0;
      checks++; if (out_valid_o !== 2'b11) begin failures++; $display("FAIL basic_valid got=%b exp=11", out_valid_o); end
      checks++; if (out_inst_o !== {32'h2, 32'h1}) begin failures++; $display("FAIL basic_inst got=%h exp=%h", out_inst_o, {32'h2, 32'h1}); end
      checks++; if (out_pc_o !== {32'h1c000004, 32'h1c000000}) begin failures++; $display("FAIL basic_pc got=%h", out_pc_o); end
      cyc();
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL basic_drained got=%b exp=00", out_valid_o); end
      id_allowin_i = 1'b0;
   endtask

   task automatic test_backpressure();
      id_allowin_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (can_req_o !== 1'b1) begin failures++; $display("FAIL bp_can_req_%0d got=%b exp=1", i, can_req_o); end
         fire(32'h1c000100 + 32'(8 * i), 2'b11, 1'b0, '0);
         cyc();
      end
      unfire();
      checks++; if (can_req_o !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", can_req_o); end
      for (int i = 0; i < 4; i++) begin
         data_ok_i = 1'b1; rdata_i = {32'hA000 + 32'(2 * i + 1), 32'hA000 + 32'(2 * i)};
         cyc();
      end
      data_ok_i = 1'b0;
      checks++; if (can_req_o !== 1'b0) begin failures++; $display("FAIL bp_q_full got=%b exp=0", can_req_o); end
      id_allowin_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid_o !== 2'b11 || out_pc_o !== {32'h1c000104 + 32'(8 * i), 32'h1c000100 + 32'(8 * i)})
            begin failures++; $display("FAIL bp_drain_pc_%0d got=%b/%h", i, out_valid_o, out_pc_o); end
         checks++; if (out_inst_o !== {32'hA000 + 32'(2 * i + 1), 32'hA000 + 32'(2 * i)})
            begin failures++; $display("FAIL bp_drain_inst_%0d got=%h", i, out_inst_o); end
         cyc();
      end
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL bp_empty got=%b exp=00", out_valid_o); end
      checks++; if (can_req_o !== 1'b1) begin failures++; $display("FAIL bp_can_req_after got=%b exp=1", can_req_o); end
      id_allowin_i = 1'b0;
   endtask

   task automatic test_flush_inflight();
      id_allowin_i = 1'b0;
      fire(32'h1c000200, 2'b11, 1'b0, '0); cyc();
      unfire(); data_ok_i = 1'b1; rdata_i = {32'hD1, 32'hD0}; cyc();
      data_ok_i = 1'b0;
      fire(32'h1c000208, 2'b11, 1'b0, '0); cyc();
      fire(32'h1c000210, 2'b11, 1'b0, '0); cyc();
      unfire();
      checks++; if (out_valid_o !== 2'b11) begin failures++; $display("FAIL fl_pre got=%b exp=11", out_valid_o); end
      flush_i = 1'b1; cyc(); flush_i = 1'b0;
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL fl_cleared got=%b exp=00", out_valid_o); end
      id_allowin_i = 1'b1;
      fire(32'h1c001000, 2'b11, 1'b0, '0); cyc();
      unfire();
      for (int i = 0; i < 2; i++) begin
         data_ok_i = 1'b1; rdata_i = {32'hBAD0, 32'hBAD0 + 32'(i)}; cyc();
         data_ok_i = 1'b0;
         checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL fl_drop_%0d got=%b exp=00", i, out_valid_o); end
      end
      data_ok_i = 1'b1; rdata_i = {32'hC1, 32'hC0}; cyc();
      data_ok_i = 1'b0;
      checks++; if (out_valid_o !== 2'b11) begin failures++; $display("FAIL fl_new_valid got=%b exp=11", out_valid_o); end
      checks++; if (out_pc_o !== {32'h1c001004, 32'h1c001000}) begin failures++; $display("FAIL fl_new_pc got=%h", out_pc_o); end
      checks++; if (out_inst_o !== {32'hC1, 32'hC0}) begin failures++; $display("FAIL fl_new_inst got=%h", out_inst_o); end
      cyc();
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL fl_pop got=%b exp=00", out_valid_o); end
      id_allowin_i = 1'b0;
   endtask

   task automatic test_flush_coincident();
      id_allowin_i = 1'b0;
      fire(32'h1c000300, 2'b11, 1'b0, '0); cyc();
      fire(32'h1c000400, 2'b11, 1'b0, '0);
      flush_i = 1'b1; data_ok_i = 1'b1; rdata_i = {32'hF1, 32'hF0};
      cyc();
      flush_i = 1'b0; data_ok_i = 1'b0; unfire();
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL co_after_flush got=%b exp=00", out_valid_o); end
      fire(32'h1c002000, 2'b11, 1'b0, '0); cyc();
      unfire();
      data_ok_i = 1'b1; rdata_i = {32'h61, 32'h60}; cyc();
      data_ok_i = 1'b0;
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL co_stale_hidden got=%b exp=00", out_valid_o); end
      data_ok_i = 1'b1; rdata_i = {32'hE1, 32'hE0}; cyc();
      data_ok_i = 1'b0;
      checks++; if (out_valid_o !== 2'b11 || out_inst_o !== {32'hE1, 32'hE0})
         begin failures++; $display("FAIL co_new_data got=%b/%h exp=11/%h", out_valid_o, out_inst_o, {32'hE1, 32'hE0}); end
      checks++; if (out_pc_o !== {32'h1c002004, 32'h1c002000}) begin failures++; $display("FAIL co_new_pc got=%h", out_pc_o); end
      id_allowin_i = 1'b1; cyc(); id_allowin_i = 1'b0;
   endtask

   task automatic test_exception();
      id_allowin_i = 1'b0;
      fire(32'h1c000000, 2'b11, 1'b0, '0); cyc();
      fire(32'h1c000008, 2'b01, 1'b1, 20'h00042); cyc();
      unfire();
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL ex_no_jump got=%b exp=00", out_valid_o); end
      data_ok_i = 1'b1; rdata_i = {32'h11, 32'h10}; cyc();
      data_ok_i = 1'b0; cyc();
      checks++; if (out_valid_o !== 2'b11 || out_excep_en_o !== 2'b00)
         begin failures++; $display("FAIL ex_insts_first got=%b/%b exp=11/00", out_valid_o, out_excep_en_o); end
      checks++; if (out_pc_o !== {32'h1c000004, 32'h1c000000}) begin failures++; $display("FAIL ex_insts_pc got=%h", out_pc_o); end
      id_allowin_i = 1'b1; cyc();
      checks++; if (out_valid_o !== 2'b01 || out_excep_en_o !== 2'b01)
         begin failures++; $display("FAIL ex_slot0 got=%b/%b exp=01/01", out_valid_o, out_excep_en_o); end
      checks++; if (out_pc_o !== {32'h0, 32'h1c000008} || out_inst_o !== 64'h0)
         begin failures++; $display("FAIL ex_pc_inst got=%h/%h", out_pc_o, out_inst_o); end
      checks++; if (out_exc_type_o !== {20'h0, 20'h00042}) begin failures++; $display("FAIL ex_type got=%h exp=42", out_exc_type_o); end
      cyc();
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL ex_popped got=%b exp=00", out_valid_o); end
      id_allowin_i = 1'b0;
      fire(32'h1c000020, 2'b01, 1'b1, 20'h00100); cyc();
      fire(32'h1c000030, 2'b01, 1'b0, '0); cyc();
      unfire();
      data_ok_i = 1'b1; rdata_i = {32'hBAD, 32'h77}; cyc();
      data_ok_i = 1'b0;
      checks++; if (out_valid_o !== 2'b01 || out_excep_en_o !== 2'b01)
         begin failures++; $display("FAIL ex_youngest got=%b/%b exp=01/01", out_valid_o, out_excep_en_o); end
      id_allowin_i = 1'b1; cyc();
      checks++; if (out_valid_o !== 2'b01 || out_excep_en_o !== 2'b00 || out_pc_o !== {32'h0, 32'h1c000030} || out_inst_o !== {32'h0, 32'h77})
         begin failures++; $display("FAIL ex_after got=%b/%b/%h/%h", out_valid_o, out_excep_en_o, out_pc_o, out_inst_o); end
      cyc();
      checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL ex_after_pop got=%b exp=00", out_valid_o); end
      id_allowin_i = 1'b0;
   endtask

   task automatic test_partial_wrap();
      id_allowin_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         fire(32'h1c003000 + 32'(16 * i), 2'b01, 1'b0, '0); cyc();
         unfire();
         data_ok_i = 1'b1; rdata_i = {32'hDEAD0000 + 32'(i), 32'hC00 + 32'(i)}; cyc();
         data_ok_i = 1'b0;
         checks++; if (out_valid_o !== 2'b01 || out_pc_o !== {32'h0, 32'h1c003000 + 32'(16 * i)})
            begin failures++; $display("FAIL wrap_pc_%0d got=%b/%h", i, out_valid_o, out_pc_o); end
         checks++; if (out_inst_o !== {32'h0, 32'hC00 + 32'(i)})
            begin failures++; $display("FAIL wrap_inst_%0d got=%h", i, out_inst_o); end
      end
      cyc();
      checks++; if (out_valid_o !== 2'b00 || can_req_o !== 1'b1)
         begin failures++; $display("FAIL wrap_end got=%b/%b exp=00/1", out_valid_o, can_req_o); end
      id_allowin_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_flush_inflight();
      test_flush_coincident();
      test_exception();
      test_partial_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
